rr_mux_arb: RTL

- Parametrised, registered N:1 data multiplexer with built-in arbitration. It succeeds the fixed 8-input, 8-bit combinational selector.
- Up to N requesters present valid/data. One winner per cycle is chosen by round-robin, fixed-priority or manual select, and its word is loaded into a single output register with a valid/ready handshake.
- Used in the CPU datapath wherever several producers (ALU, memory read, immediate, PC+1, ...) compete for one bus or register-file write port.

---
 rtl/cpu_pkg.sv | 10 +
 rtl/rr_grant.sv | 34 +++
 rtl/rr_mux_arb.sv | 54 +++++
 3 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath constants and multiplexer mode encodings
package cpu_pkg;
  typedef enum logic [1:0] {
    MODE_RR     = 2'b00,
    MODE_FIXED  = 2'b01,
    MODE_MANUAL = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_e;
  localparam int DATA_W = 8;
endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational winner selection for round-robin, fixed-priority and manual modes
module rr_grant import cpu_pkg::*; #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);
  // Scan from the far end down so the last hit is the highest-priority candidate
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mode == MODE_MANUAL) begin
        if (sel == SEL_W'(k) && req[k]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SEL_W'(k);
        end
      end else if (mode == MODE_FIXED) begin
        if (req[k]) begin
          gnt_valid = 1'b1;
          gnt_idx   = SEL_W'(k);
        end
      end else if (req[SEL_W'((int'(ptr) + k) % N)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'((int'(ptr) + k) % N);
      end
    end
  end
endmodule

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: registered N:1 multiplexer with built-in arbitration and valid/ready output
module rr_mux_arb import cpu_pkg::*; #(
  parameter int WIDTH = DATA_W,
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SEL_W-1:0]   out_sel
);
  logic [SEL_W-1:0] ptr;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             load_en;
  logic             rr_mode;

  rr_grant #(.N(N), .SEL_W(SEL_W)) u_grant (
    .req       (in_valid),
    .ptr       (ptr),
    .mode      (mode),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign load_en  = !out_valid || out_ready;
  assign rr_mode  = mode != MODE_FIXED && mode != MODE_MANUAL;
  assign in_ready = (load_en && gnt_valid && !rst) ? N'(1) << gnt_idx : '0;

  // Output register and round-robin pointer advance only when the output slot is free
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      out_valid <= gnt_valid;
      if (gnt_valid) begin
        out_data <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
        out_sel  <= gnt_idx;
        if (rr_mode) ptr <= (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end
endmodule
